// File: rtl/seq_restoring_divider_if.sv
// Start/busy/done handshake bundle for the sequential restoring divider.
interface seq_restoring_divider_if #(
    parameter int unsigned DW = 16,
    parameter int unsigned VW = 8
);
    logic          start;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          busy;
    logic          done;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div_by_zero;

    // Requester side: issues operands and start, observes results
    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    // Divider side
    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, MSB first.
// Divide-by-zero short-circuits straight to DONE with an all-ones quotient.
module seq_restoring_divider #(
    parameter int unsigned DW = 16,
    parameter int unsigned VW = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    seq_restoring_divider_if.slave bus
);
    localparam int unsigned CW = $clog2(DW);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q;
    state_t        state_n;

    logic [DW-1:0] dvd_q;       // dividend bits still to consume; quotient bits shift in at LSB
    logic [VW-1:0] dvs_q;
    logic [VW-1:0] prem_q;      // partial remainder, always < divisor between steps
    logic [CW-1:0] cnt_q;

    logic          busy_q;
    logic          done_q;
    logic          dbz_q;
    logic [DW-1:0] quo_q;
    logic [VW-1:0] rem_q;

    logic [VW:0]   shifted_c;
    logic [VW+1:0] trial_c;
    logic          neg_c;
    logic [VW-1:0] prem_step_c;
    logic [DW-1:0] dvd_step_c;
    logic          accept_c;
    logic          zero_div_c;
    logic          last_c;
    logic          unused_trial_bit;

    // One restoring step: shift in next dividend bit, trial subtract, restore on borrow
    always_comb begin
        shifted_c   = {prem_q, dvd_q[DW-1]};
        trial_c     = (VW+2)'(shifted_c) - (VW+2)'(dvs_q);
        neg_c       = trial_c[VW+1];
        prem_step_c = neg_c ? shifted_c[VW-1:0] : trial_c[VW-1:0];
        dvd_step_c  = {dvd_q[DW-2:0], ~neg_c};
    end

    // A non-negative trial result is below the divisor, so its bit VW is always zero
    assign unused_trial_bit = trial_c[VW];

    assign accept_c   = (state_q == IDLE) && bus.start;
    assign zero_div_c = (bus.divisor == '0);
    assign last_c     = (state_q == RUN) && (cnt_q == CW'(DW - 1));

    // Next-state logic
    always_comb begin
        state_n = state_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_n = zero_div_c ? DONE : RUN;
                end
            end
            RUN: begin
                if (last_c) begin
                    state_n = DONE;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // Datapath, iteration counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd_q  <= '0;
            dvs_q  <= '0;
            prem_q <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            quo_q  <= '0;
            rem_q  <= '0;
        end else begin
            busy_q <= (state_n == RUN);
            done_q <= (state_n == DONE);
            if (accept_c) begin
                if (zero_div_c) begin
                    quo_q <= '1;
                    rem_q <= '0;
                    dbz_q <= 1'b1;
                end else begin
                    dvd_q  <= bus.dividend;
                    dvs_q  <= bus.divisor;
                    prem_q <= '0;
                    cnt_q  <= '0;
                end
            end else if (state_q == RUN) begin
                dvd_q  <= dvd_step_c;
                prem_q <= prem_step_c;
                cnt_q  <= cnt_q + CW'(1);
                if (last_c) begin
                    quo_q <= dvd_step_c;
                    rem_q <= prem_step_c;
                    dbz_q <= 1'b0;
                end
            end
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quo_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: doc/seq_restoring_divider.md
Name: seq_restoring_divider

Overview:
- Multi-cycle unsigned restoring divider: the inverse of the adder-tree multiplier datapath.
- Takes a 16-bit dividend (e.g. a multiplier product p) and an 8-bit divisor, and returns quotient and remainder.
- One quotient bit is resolved per clock, behind a start/busy/done handshake.
- Sits beside the multiplier in the arithmetic section and is used to check and undo products.

Parameters:
- DW, 16: dividend and quotient width. Also the iteration count.
- VW, 8: divisor and remainder width.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- dividend  input  DW  unsigned dividend; sampled on accepted start
- divisor  input  VW  unsigned divisor; sampled on accepted start
- busy  output  1  high while iterating (RUN)
- done  output  1  one-cycle pulse; results valid from this cycle
- quotient  output  DW  registered quotient
- remainder  output  VW  registered remainder
- div_by_zero  output  1  registered flag for the last completed operation

Behaviour:

Reset:
- Clock and reset: single clock. Reset is asynchronous and active-low on rst_n.
- rst_n low forces state=IDLE; busy, done, quotient, remainder, div_by_zero and the iteration counter to 0.
- This applies at any time, including mid-RUN: the in-flight operation is discarded and produces no done pulse.

States:
- IDLE: busy=0, done=0.
  - start=1 at edge k with divisor!=0: latch operands, clear the partial remainder (VW+1 bits internally), set counter=0, go to RUN.
  - start=1 at edge k with divisor==0: go to DONE with quotient={DW{1}}, remainder=0, div_by_zero=1. done is high in the cycle after edge k, so latency is 1.
- RUN: busy=1. Each edge performs one restoring step, MSB first:
  - shift the partial remainder left, bringing in the next dividend bit;
  - trial subtract the divisor;
  - if the result is non-negative, keep it and set quotient bit=1; otherwise restore and set quotient bit=0.
  - The counter increments on each step. After DW steps (edge k+DW), register quotient, remainder and div_by_zero=0, then go to DONE.
- DONE: done=1, busy=0 for exactly one cycle, then go to IDLE on the next edge.

Handshake and timing:
- Normal latency: start accepted at edge k, done high between edges k+DW and k+DW+1 (DW cycles).
- Back-to-back throughput: one operation per DW+2 cycles, because start is accepted only in IDLE.
- start is ignored in RUN and DONE. dividend and divisor may change freely after acceptance.

Outputs and arithmetic:
- quotient, remainder and div_by_zero hold the last completed result until the next done. They do not change during RUN.
- All arithmetic is unsigned. The invariants quotient*divisor + remainder == dividend and remainder < divisor hold whenever div_by_zero=0.
- dividend=0 gives quotient=0, remainder=0 at normal latency.
- divisor=1 gives quotient=dividend, remainder=0.
- divisor greater than dividend gives quotient=0, remainder=dividend[VW-1:0].

Test Plan:
- dividend=15, divisor=3, start pulse -> done exactly 16 cycles after acceptance; quotient=5, remainder=0, div_by_zero=0, busy high for 16 cycles.
- Sequential ops 65025/255, 510/2, 1000/7 -> quotient/remainder of 255/0, 255/0 and 142/6 respectively. Each done pulse lasts exactly 1 cycle.
- dividend=0xFFFF, divisor=1 -> quotient=0xFFFF, remainder=0. Also dividend=5, divisor=200 -> quotient=0, remainder=5.
- dividend=100, divisor=0 -> done 1 cycle after acceptance; quotient=0xFFFF, remainder=0, div_by_zero=1. The next valid op then clears div_by_zero.
- 1000/7 started, then start re-pulsed mid-RUN with 9/3 -> second start ignored; result 142/6 at the original done time.
- rst_n pulled low 5 cycles into a RUN -> all outputs 0 immediately, no done pulse. After release, a fresh 100/10 gives quotient=10, remainder=0.
